// File: rtl/mem_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : mem_arb_pkg
// Purpose  : Shared types, default sizes and the round-robin pick helper
//            for the memory arbiter and any other round-robin shared resource.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int DEFAULT_AW      = 5;
    localparam int DEFAULT_DW      = 8;
    localparam int DEFAULT_TIMEOUT = 16;

    // Widest requester vector the picker handles, and the index width for it
    localparam int MAX_NREQ = 4;
    localparam int IDX_W    = 2;

    // First set request found scanning upward from ptr, wrapping modulo nreq.
    // With no request set the result is ptr and the caller must ignore it.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [MAX_NREQ-1:0] req_vec,
        input logic [IDX_W-1:0]    ptr,
        input int                  nreq
    );
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            idx = (int'(ptr) + i) % nreq;
            if ((i < nreq) && !found && req_vec[idx[IDX_W-1:0]]) begin
                pick  = idx[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter
// Purpose  : Combinational round-robin picker. Searches the request vector
//            starting at ptr and returns a one-hot grant plus its index.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [MAX_NREQ-1:0] req_ext;
    logic [IDX_W-1:0]    ptr_ext;
    logic [IDX_W-1:0]    pick;

    // Widen to the helper's fixed vector size and pick the winner
    always_comb begin
        req_ext             = '0;
        req_ext[NREQ-1:0]   = req;
        ptr_ext             = '0;
        ptr_ext[IW-1:0]     = ptr;
        pick                = rr_pick(req_ext, ptr_ext, NREQ);
        idx                 = pick[IW-1:0];
        any                 = |req;
    end

    // One-hot decode of the winning index, empty when nothing is requested
    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_grant
            assign grant[i] = any && (idx == IW'(i));
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : mem_arbiter
// Purpose  : Round-robin arbiter sharing one handshake memory among NREQ
//            requesters, with request latching and a no-ack watchdog.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int AW      = DEFAULT_AW,
    parameter int DW      = DEFAULT_DW,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      we,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   wdata,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      err,
    output logic [DW-1:0]        rdata,
    output logic                 busy,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata,
    input  logic                 mem_ack
);

    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WDW = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
    localparam logic [IW-1:0]  LAST_IDX = IW'(NREQ - 1);

    arb_state_t      state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   owner;
    logic [NREQ-1:0] owner_oh;
    logic [WDW-1:0]  wd;
    logic [IW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_grant;
    logic            pick_any;
    logic [IW-1:0]   ptr_next;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Rotation point after the current owner finishes, wrapping at NREQ
    assign ptr_next = (owner == LAST_IDX) ? '0 : owner + 1'b1;

    assign busy = (state == BUSY);

    // Arbitration FSM; every memory-facing output is registered and, while
    // BUSY, driven only from the copies latched at grant time
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            owner_oh  <= '0;
            wd        <= '0;
            done      <= '0;
            err       <= '0;
            rdata     <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            done <= '0;
            err  <= '0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner     <= pick_idx;
                        owner_oh  <= pick_grant;
                        mem_read  <= !we[pick_idx];
                        mem_write <= we[pick_idx];
                        mem_addr  <= addr[pick_idx*AW +: AW];
                        mem_wdata <= wdata[pick_idx*DW +: DW];
                        wd        <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        // Writes leave the last read result in place
                        if (!mem_write) begin
                            rdata <= mem_rdata;
                        end
                        done      <= owner_oh;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        ptr       <= ptr_next;
                        state     <= IDLE;
                    end else if (wd == WD_LAST) begin
                        // Dropping read/write also withdraws the request
                        // from the memory
                        err       <= owner_oh;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        ptr       <= ptr_next;
                        state     <= IDLE;
                    end else begin
                        // Abort fires at WD_LAST, so the count never wraps
                        wd <= wd + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter with a 32x8
//            handshake memory model of programmable latency.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

    localparam int NREQ    = 2;
    localparam int AW      = 5;
    localparam int DW      = 8;
    localparam int TIMEOUT = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    done;
    logic [NREQ-1:0]    err;
    logic [DW-1:0]      rdata;
    logic               busy;
    logic               mem_read;
    logic               mem_write;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;
    logic               mem_ack;

    int checks = 0;
    int errors = 0;

    // Memory model state
    logic [DW-1:0] mem [32];
    int            lat;
    bit            never_ack;
    int            cnt;
    bit            wait_low;
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    always #5 clk = ~clk;

    mem_arbiter #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .busy      (busy),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    // Handshake memory: acks lat edges after first seeing a request, then
    // waits for controls to drop before accepting another
    always @(posedge clk) begin
        mem_ack   <= 1'b0;
        mem_rdata <= '0;
        if (pre_en) mem[pre_addr] <= pre_data;
        if (rst) begin
            cnt      <= 0;
            wait_low <= 1'b0;
        end else if (wait_low) begin
            if (!mem_read && !mem_write) wait_low <= 1'b0;
        end else if (mem_read || mem_write) begin
            if (!never_ack && cnt >= lat - 1) begin
                mem_ack   <= 1'b1;
                mem_rdata <= mem[mem_addr];
                if (mem_write) mem[mem_addr] <= mem_wdata;
                wait_low  <= 1'b1;
                cnt       <= 0;
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clk);
        pre_en   = 1'b0;
    endtask

    // Wait (bounded) for a done/err pulse; reports owner, kind, negedges
    // elapsed and whether controls stayed high while waiting
    task automatic wait_evt(output int who, output logic was_err,
                            output int ncyc, output logic ctrl_ok);
        who     = -1;
        was_err = 1'b0;
        ncyc    = 0;
        ctrl_ok = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done != '0 || err != '0) begin
                ncyc    = i;
                was_err = (err != '0);
                who     = (done[1] || err[1]) ? 1 : 0;
                break;
            end else if (!(mem_read || mem_write)) begin
                ctrl_ok = 1'b0;
            end
        end
        chk("evt_seen", 32'(ncyc != 0), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int   who;
        logic was_err;
        int   ncyc;
        logic ctrl_ok;

        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        lat = 3; never_ack = 1'b0;

        preload(5'd5, 8'hA5);
        preload(5'd7, 8'h00);
        preload(5'd8, 8'h00);
        preload(5'd0, 8'h77);
        @(negedge clk);

        // Reset values
        chk("rst_done",  32'(done), 32'h0);
        chk("rst_err",   32'(err), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_mem_ctrl", 32'({mem_read, mem_write}), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        rst = 1'b0;

        // Single read of addr 5 by requester 0
        req = 2'b01; we = 2'b00; addr = {5'd0, 5'd5};
        @(negedge clk);
        chk("rd_busy", 32'(busy), 32'h1);
        chk("rd_ctrl", 32'({mem_read, mem_write}), 32'h2);
        chk("rd_addr", 32'(mem_addr), 32'h5);
        wait_evt(who, was_err, ncyc, ctrl_ok);
        chk("rd_owner", 32'(who), 32'd0);
        chk("rd_not_err", 32'(was_err), 32'h0);
        chk("rd_latency", 32'(ncyc), 32'd4);
        chk("rd_ctrl_stable", 32'(ctrl_ok), 32'h1);
        chk("rd_rdata", 32'(rdata), 32'hA5);
        chk("rd_ctrl_low", 32'({mem_read, mem_write}), 32'h0);
        req = 2'b00;
        @(negedge clk);
        chk("rd_done_once", 32'(done), 32'h0);
        chk("rd_idle", 32'({busy, mem_read}), 32'h0);

        // Requester 1 writes 0x3C to addr 31, then reads it back
        req = 2'b10; we = 2'b10; addr = {5'd31, 5'd0}; wdata = {8'h3C, 8'h00};
        wait_evt(who, was_err, ncyc, ctrl_ok);
        chk("wr_owner", 32'(who), 32'd1);
        chk("wr_not_err", 32'(was_err), 32'h0);
        chk("wr_rdata_kept", 32'(rdata), 32'hA5);
        req = 2'b00; we = 2'b00;
        @(negedge clk);
        req = 2'b10;
        wait_evt(who, was_err, ncyc, ctrl_ok);
        chk("wrrd_owner", 32'(who), 32'd1);
        chk("wrrd_rdata", 32'(rdata), 32'h3C);
        req = 2'b00;
        @(negedge clk);

        // Contention from reset: both write, expect 0,1,0,1
        rst = 1'b1;
        req = 2'b11; we = 2'b11; addr = {5'd3, 5'd2}; wdata = {8'h22, 8'h11};
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_evt(who, was_err, ncyc, ctrl_ok);
            chk("rr_order", 32'(who), 32'(k % 2));
            if (k > 0) chk("rr_gap", 32'(ncyc), 32'd5);
            if (k == 3) req = 2'b00;
        end
        @(negedge clk);
        chk("rr_idle", 32'(busy), 32'h0);
        chk("rr_mem2", 32'(mem[2]), 32'h11);
        chk("rr_mem3", 32'(mem[3]), 32'h22);
        we = 2'b00;

        // Requester changes addr and drops req mid-transaction
        lat = 6;
        req = 2'b01; we = 2'b01; addr = {5'd0, 5'd7}; wdata = {8'h00, 8'h5A};
        @(negedge clk);
        chk("mis_busy", 32'(busy), 32'h1);
        addr = {5'd0, 5'd8}; wdata = {8'h00, 8'hFF}; req = 2'b00; we = 2'b00;
        @(negedge clk);
        chk("mis_addr_held", 32'(mem_addr), 32'h7);
        chk("mis_wdata_held", 32'(mem_wdata), 32'h5A);
        wait_evt(who, was_err, ncyc, ctrl_ok);
        chk("mis_owner", 32'(who), 32'd0);
        chk("mis_not_err", 32'(was_err), 32'h0);
        chk("mis_mem7", 32'(mem[7]), 32'h5A);
        chk("mis_mem8", 32'(mem[8]), 32'h00);
        @(negedge clk);

        // Timeout: memory never acks
        lat = 3; never_ack = 1'b1;
        req = 2'b10; we = 2'b00; addr = {5'd4, 5'd0};
        wait_evt(who, was_err, ncyc, ctrl_ok);
        chk("to_owner", 32'(who), 32'd1);
        chk("to_is_err", 32'(was_err), 32'h1);
        chk("to_cycles", 32'(ncyc), 32'(TIMEOUT + 1));
        chk("to_ctrl_held", 32'(ctrl_ok), 32'h1);
        chk("to_no_done", 32'(done), 32'h0);
        chk("to_ctrl_low", 32'({busy, mem_read, mem_write}), 32'h0);
        never_ack = 1'b0; req = 2'b00;
        @(negedge clk);
        chk("to_err_once", 32'(err), 32'h0);
        req = 2'b01; addr = {5'd0, 5'd5};
        wait_evt(who, was_err, ncyc, ctrl_ok);
        chk("to_next_owner", 32'(who), 32'd0);
        chk("to_next_ok", 32'(was_err), 32'h0);
        chk("to_next_rdata", 32'(rdata), 32'hA5);
        req = 2'b00;
        @(negedge clk);

        // Reset mid-transaction
        lat = 8;
        req = 2'b01; we = 2'b00; addr = {5'd0, 5'd0};
        @(negedge clk);
        chk("mr_busy", 32'(busy), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_busy_low", 32'(busy), 32'h0);
        chk("mr_ctrl_low", 32'({mem_read, mem_write}), 32'h0);
        chk("mr_no_evt", 32'({done, err}), 32'h0);
        chk("mr_rdata", 32'(rdata), 32'h0);
        chk("mr_addr", 32'(mem_addr), 32'h0);
        rst = 1'b0;
        wait_evt(who, was_err, ncyc, ctrl_ok);
        chk("mr_owner", 32'(who), 32'd0);
        chk("mr_not_err", 32'(was_err), 32'h0);
        chk("mr_rdata_after", 32'(rdata), 32'h77);
        req = 2'b00;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
